// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the UART debug-frame checker.
// Frame layout: "DBG: " + 0x00..PAYLOAD_LEN-1 + CR LF.
package fpga_template_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_TAIL_CR = 3'd3,
        ST_TAIL_LF = 3'd4
    } dbg_chk_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_HDR     = 3'd1,
        ERR_PAYLOAD = 3'd2,
        ERR_TAIL    = 3'd3,
        ERR_TIMEOUT = 3'd4
    } dbg_chk_err_t;

    localparam logic [7:0] DBG_HDR_D     = 8'h44;
    localparam logic [7:0] DBG_HDR_B     = 8'h42;
    localparam logic [7:0] DBG_HDR_G     = 8'h47;
    localparam logic [7:0] DBG_HDR_COLON = 8'h3A;
    localparam logic [7:0] DBG_HDR_SPACE = 8'h20;
    localparam logic [7:0] DBG_CR        = 8'h0D;
    localparam logic [7:0] DBG_LF        = 8'h0A;

    localparam int unsigned HDR_IDX_W = 3;
    localparam logic [HDR_IDX_W-1:0] HDR_LAST = 3'd4;
    localparam int unsigned TMO_W = 16;

    // Expected header byte at a given header position (0 is the 'D').
    function automatic logic [7:0] hdr_byte(input logic [HDR_IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = DBG_HDR_D;
            3'd1:    b = DBG_HDR_B;
            3'd2:    b = DBG_HDR_G;
            3'd3:    b = DBG_HDR_COLON;
            3'd4:    b = DBG_HDR_SPACE;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_chk_timeout.sv
// Inter-byte gap counter for dbg_seq_checker; flags expiry when a frame
// has seen TIMEOUT_CYCLES consecutive cycles without a byte.
module dbg_chk_timeout
    import fpga_template_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'h0000_0400
) (
    input  logic clk,
    input  logic resetb,
    input  logic active,
    input  logic rx_valid,
    output logic expired_c
);

    logic [TMO_W-1:0] gap_q;

    // A byte arriving on the expiry cycle wins, so rx_valid masks the flag.
    assign expired_c = active && !rx_valid &&
                       (gap_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gap_q <= '0;
        end else if (rx_valid || !active || expired_c) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + TMO_W'(1);
        end
    end

endmodule

// File: rtl/dbg_seq_checker.sv
// Receive-side checker for the "DBG: " debug frame with saturating counters.
// Optional inter-byte timeout enabled by defining DBG_CHK_TIMEOUT_EN.
module dbg_seq_checker
    import fpga_template_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN    = 16,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [7:0]       err_byte,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 255 || CNT_W < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("dbg_seq_checker: parameter out of range");
    end

    dbg_chk_state_t          state_q, state_nx;
    logic [HDR_IDX_W-1:0]    hdr_idx_q, hdr_idx_nx;
    logic [7:0]              pay_idx_q, pay_idx_nx;
    dbg_chk_err_t            err_code_q, err_code_nx;
    logic [7:0]              err_byte_nx;
    logic [CNT_W-1:0]        ok_cnt_nx, err_cnt_nx;
    logic                    frame_ok_nx, frame_err_nx;
    logic                    fail;
    dbg_chk_err_t            fail_code;
    logic [7:0]              fail_byte;
    logic                    expired_c;

    assign err_code = err_code_q;

`ifdef DBG_CHK_TIMEOUT_EN
    dbg_chk_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .resetb    (resetb),
        .active    (busy),
        .rx_valid  (rx_valid),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    // Frame sequencing, error capture and counter updates.
    always_comb begin
        state_nx     = state_q;
        hdr_idx_nx   = hdr_idx_q;
        pay_idx_nx   = pay_idx_q;
        err_code_nx  = err_code_q;
        err_byte_nx  = err_byte;
        ok_cnt_nx    = ok_cnt;
        err_cnt_nx   = err_cnt;
        frame_ok_nx  = 1'b0;
        frame_err_nx = 1'b0;
        fail         = 1'b0;
        fail_code    = ERR_NONE;
        fail_byte    = rx_data;

        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == DBG_HDR_D) begin
                        state_nx    = ST_HDR;
                        hdr_idx_nx  = 3'd1;
                        err_code_nx = ERR_NONE;
                        err_byte_nx = 8'h00;
                    end
                end
                ST_HDR: begin
                    if (rx_data == hdr_byte(hdr_idx_q)) begin
                        if (hdr_idx_q == HDR_LAST) begin
                            state_nx   = ST_PAYLOAD;
                            pay_idx_nx = 8'h00;
                        end else begin
                            hdr_idx_nx = hdr_idx_q + 3'd1;
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_HDR;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_data == pay_idx_q) begin
                        if (pay_idx_q == 8'(PAYLOAD_LEN - 1)) begin
                            state_nx = ST_TAIL_CR;
                        end else begin
                            pay_idx_nx = pay_idx_q + 8'd1;
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_PAYLOAD;
                    end
                end
                ST_TAIL_CR: begin
                    if (rx_data == DBG_CR) begin
                        state_nx = ST_TAIL_LF;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_TAIL;
                    end
                end
                ST_TAIL_LF: begin
                    if (rx_data == DBG_LF) begin
                        state_nx    = ST_IDLE;
                        frame_ok_nx = 1'b1;
                        if (ok_cnt != '1) begin
                            ok_cnt_nx = ok_cnt + CNT_W'(1);
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_TAIL;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (expired_c) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
            fail_byte = 8'h00;
        end

        // A mismatching 'D' is treated as the start of the next frame.
        if (fail) begin
            frame_err_nx = 1'b1;
            err_code_nx  = fail_code;
            err_byte_nx  = fail_byte;
            if (err_cnt != '1) begin
                err_cnt_nx = err_cnt + CNT_W'(1);
            end
            if (rx_valid && rx_data == DBG_HDR_D) begin
                state_nx   = ST_HDR;
                hdr_idx_nx = 3'd1;
            end else begin
                state_nx = ST_IDLE;
            end
        end

        if (clr_cnt) begin
            ok_cnt_nx   = '0;
            err_cnt_nx  = '0;
            err_code_nx = ERR_NONE;
            err_byte_nx = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            hdr_idx_q  <= '0;
            pay_idx_q  <= '0;
            busy       <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_byte   <= 8'h00;
            ok_cnt     <= '0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_nx;
            hdr_idx_q  <= hdr_idx_nx;
            pay_idx_q  <= pay_idx_nx;
            busy       <= (state_nx != ST_IDLE);
            frame_ok   <= frame_ok_nx;
            frame_err  <= frame_err_nx;
            err_code_q <= err_code_nx;
            err_byte   <= err_byte_nx;
            ok_cnt     <= ok_cnt_nx;
            err_cnt    <= err_cnt_nx;
        end
    end

endmodule

// File: tb/tb_dbg_seq_checker.sv
// Self-checking bench for dbg_seq_checker: directed frame scenarios plus
// randomized byte streams checked against a frame-position reference model.
module tb_dbg_seq_checker;

    localparam int FLEN = 23;

    logic       clk;
    logic       resetb;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clr_cnt;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic [7:0] err_byte;
    logic [7:0] ok_cnt;
    logic [7:0] err_cnt;

    int n_tests;
    int n_fail;
    int ok_pulses;
    int err_pulses;
    int both_high;

    logic [7:0] frame [FLEN];

    // Reference model: position within the expected frame byte array.
    int         m_pos;
    logic       m_ok;
    logic       m_err;
    int         m_code;
    logic [7:0] m_byte;
    int         m_okc;
    int         m_errc;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       c;
    } stim_t;

    dbg_seq_checker #(
        .PAYLOAD_LEN    (16),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (32'h40)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_byte  (err_byte),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int region_code(input int pos);
        if (pos <= 4) return 1;
        if (pos <= 20) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_ok = 0; m_err = 0; m_code = 0; m_byte = 0;
        m_okc = 0; m_errc = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        m_ok = 0;
        m_err = 0;
        if (v) begin
            if (m_pos == 0) begin
                if (d == 8'h44) begin
                    m_pos = 1; m_code = 0; m_byte = 0;
                end
            end else if (d == frame[m_pos]) begin
                m_pos++;
                if (m_pos == FLEN) begin
                    m_pos = 0; m_ok = 1;
                    if (m_okc < 255) m_okc++;
                end
            end else begin
                m_err = 1;
                m_code = region_code(m_pos);
                m_byte = d;
                if (m_errc < 255) m_errc++;
                m_pos = (d == 8'h44) ? 1 : 0;
            end
        end
        if (c) begin
            m_okc = 0; m_errc = 0; m_code = 0; m_byte = 0;
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        clr_cnt  = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        if (frame_ok) ok_pulses++;
        if (frame_err) err_pulses++;
        if (frame_ok && frame_err) both_high++;
    endtask

    task automatic send_frame(input int gap, input logic clr_last);
        for (int i = 0; i < FLEN; i++) begin
            drive_cycle(1'b1, frame[i], clr_last && (i == FLEN - 1));
            for (int g = 0; g < gap; g++) drive_cycle(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; rx_data = 8'h00; clr_cnt = 1'b0;
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        model_reset();
        ok_pulses = 0; err_pulses = 0;
    endtask

    task automatic test_reset();
        rx_valid = 1'b0; rx_data = 8'h00; clr_cnt = 1'b0;
        resetb = 1'b0;
        #12;
        n_tests++;
        if ({busy, frame_ok, frame_err, err_code, err_byte, ok_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b ok=%b err=%b code=%0d byte=%h okc=%0d errc=%0d expected all 0",
                     busy, frame_ok, frame_err, err_code, err_byte, ok_cnt, err_cnt);
        end
        do_reset();
        drive_cycle(1'b1, 8'h55, 1'b0);
        n_tests++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_junk: got busy=%b err=%b expected 0 0", busy, frame_err);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame(15, 1'b0);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (ok_pulses !== 1 || err_pulses !== 0) begin
            n_fail++;
            $display("FAIL good_pulses: got ok=%0d err=%0d expected 1 0", ok_pulses, err_pulses);
        end
        n_tests++;
        if (ok_cnt !== 8'd1 || err_code !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_state: got okc=%0d code=%0d busy=%b expected 1 0 0", ok_cnt, err_code, busy);
        end
    endtask

    task automatic test_payload_error();
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, frame[i], 1'b0);
        drive_cycle(1'b1, 8'h06, 1'b0);
        n_tests++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0 || err_code !== 3'd2 || err_byte !== 8'h06
            || err_cnt !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL payload_err: got err=%b ok=%b code=%0d byte=%h errc=%0d busy=%b expected 1 0 2 06 1 0",
                     frame_err, frame_ok, err_code, err_byte, err_cnt, busy);
        end
        send_frame(0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (ok_cnt !== 8'd1 || err_cnt !== 8'd1 || err_code !== 3'd0 || err_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL payload_recover: got okc=%0d errc=%0d code=%0d byte=%h expected 1 1 0 00",
                     ok_cnt, err_cnt, err_code, err_byte);
        end
    endtask

    task automatic test_resync();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, frame[i], 1'b0);
        send_frame(1, 1'b0);
        n_tests++;
        if (ok_pulses !== 1 || err_pulses !== 1 || ok_cnt !== 8'd1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL resync_counts: got okp=%0d errp=%0d okc=%0d errc=%0d expected 1 1 1 1",
                     ok_pulses, err_pulses, ok_cnt, err_cnt);
        end
        n_tests++;
        if (err_code !== 3'd1 || err_byte !== 8'h44) begin
            n_fail++;
            $display("FAIL resync_sticky: got code=%0d byte=%h expected 1 44", err_code, err_byte);
        end
    endtask

    task automatic test_back_to_back_saturation();
        do_reset();
        for (int f = 0; f < 299; f++) send_frame(0, 1'b0);
        n_tests++;
        if (ok_cnt !== 8'hFF || ok_pulses !== 299) begin
            n_fail++;
            $display("FAIL sat_ok_cnt: got okc=%h pulses=%0d expected ff 299", ok_cnt, ok_pulses);
        end
        send_frame(0, 1'b1);
        n_tests++;
        if (frame_ok !== 1'b1 || ok_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL sat_clear_on_lf: got ok=%b okc=%h expected 1 00", frame_ok, ok_cnt);
        end
    endtask

    task automatic test_random();
        stim_t q[$];
        stim_t s;
        logic [7:0] b;
        int r;
        do_reset();
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                s.v = 1'b1; s.d = 8'($urandom); s.c = 1'b0; q.push_back(s);
            end
            for (int i = 0; i < FLEN; i++) begin
                b = frame[i];
                r = int'($urandom_range(0, 24));
                if (r == 0) b = 8'h44;
                else if (r == 1) b = 8'($urandom);
                else if (r == 2) b = frame[i] + 8'd1;
                s.v = 1'b1; s.d = b; s.c = ($urandom_range(0, 39) == 0); q.push_back(s);
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    s.v = 1'b0; s.d = 8'($urandom); s.c = ($urandom_range(0, 59) == 0);
                    q.push_back(s);
                end
            end
        end
        foreach (q[k]) begin
            drive_cycle(q[k].v, q[k].d, q[k].c);
            n_tests++;
            if (frame_ok !== m_ok || frame_err !== m_err || busy !== (m_pos != 0)) begin
                n_fail++;
                $display("FAIL rand_pulses[%0d]: got ok=%b err=%b busy=%b expected %b %b %b",
                         k, frame_ok, frame_err, busy, m_ok, m_err, m_pos != 0);
            end
            n_tests++;
            if (err_code !== 3'(m_code) || err_byte !== m_byte
                || ok_cnt !== 8'(m_okc) || err_cnt !== 8'(m_errc)) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: got code=%0d byte=%h okc=%0d errc=%0d expected %0d %h %0d %0d",
                         k, err_code, err_byte, ok_cnt, err_cnt, m_code, m_byte, m_okc, m_errc);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, frame[i], 1'b0);
        #2;
        resetb = 1'b0;
        #1;
        n_tests++;
        if ({busy, frame_ok, frame_err, err_code, err_byte, ok_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got busy=%b okc=%0d errc=%0d expected all 0", busy, ok_cnt, err_cnt);
        end
        do_reset();
        send_frame(2, 1'b0);
        n_tests++;
        if (ok_cnt !== 8'd1 || ok_pulses !== 1 || err_pulses !== 0) begin
            n_fail++;
            $display("FAIL midframe_recover: got okc=%0d okp=%0d errp=%0d expected 1 1 0",
                     ok_cnt, ok_pulses, err_pulses);
        end
    endtask

`ifdef DBG_CHK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        logic seen;
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, frame[i], 1'b0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            n++;
            if (frame_err) seen = 1'b1;
        end
        n_tests++;
        if (!seen || n !== 64) begin
            n_fail++;
            $display("FAIL timeout_delay: got seen=%b cycles=%0d expected 1 64", seen, n);
        end
        n_tests++;
        if (err_code !== 3'd4 || err_byte !== 8'h00 || err_cnt !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regs: got code=%0d byte=%h errc=%0d busy=%b expected 4 00 1 0",
                     err_code, err_byte, err_cnt, busy);
        end
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, frame[i], 1'b0);
        repeat (63) drive_cycle(1'b0, 8'h00, 1'b0);
        for (int i = 6; i < FLEN; i++) drive_cycle(1'b1, frame[i], 1'b0);
        n_tests++;
        if (err_pulses !== 0 || ok_pulses !== 1) begin
            n_fail++;
            $display("FAIL timeout_byte_wins: got errp=%0d okp=%0d expected 0 1", err_pulses, ok_pulses);
        end
    endtask
`else
    task automatic test_long_gap();
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, frame[i], 1'b0);
        repeat (2000) drive_cycle(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || err_pulses !== 0) begin
            n_fail++;
            $display("FAIL long_gap_wait: got busy=%b errp=%0d expected 1 0", busy, err_pulses);
        end
        for (int i = 6; i < FLEN; i++) drive_cycle(1'b1, frame[i], 1'b0);
        n_tests++;
        if (ok_pulses !== 1 || ok_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL long_gap_finish: got okp=%0d okc=%0d expected 1 1", ok_pulses, ok_cnt);
        end
    endtask
`endif

    initial begin
        n_tests = 0; n_fail = 0;
        ok_pulses = 0; err_pulses = 0; both_high = 0;
        frame[0] = 8'h44; frame[1] = 8'h42; frame[2] = 8'h47;
        frame[3] = 8'h3A; frame[4] = 8'h20;
        for (int i = 0; i < 16; i++) frame[5 + i] = 8'(i);
        frame[21] = 8'h0D; frame[22] = 8'h0A;
        model_reset();

        test_reset();
        test_good_frame();
        test_payload_error();
        test_resync();
        test_back_to_back_saturation();
        test_random();
        test_reset_midframe();
`ifdef DBG_CHK_TIMEOUT_EN
        test_timeout();
`else
        test_long_gap();
`endif
        n_tests++;
        if (both_high !== 0) begin
            n_fail++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", both_high);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
